// File: rtl/risc16_pkg.sv
// Shared types and constants for the RISC16 memory subsystem:
// loader state encoding, MMIO register offsets, default RAM depth.
package risc16_pkg;

    typedef enum logic [1:0] {
        LOAD_HI = 2'd0,
        LOAD_LO = 2'd1,
        RUN     = 2'd2
    } ld_state_t;

    localparam int MEM_WORDS_DEF = 1024;

    localparam logic [15:0] MMIO_GPIO_OUT = 16'h0000;
    localparam logic [15:0] MMIO_GPIO_IN  = 16'h0002;
    localparam logic [15:0] MMIO_CYC_CNT  = 16'h0004;

endpackage

// File: rtl/risc16_loader.sv
// Byte-stream program loader: assembles big-endian 16-bit words
// from the loader port and streams them into RAM from word 0.
module risc16_loader
    import risc16_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [7:0]    i_data,
    input  logic          i_last,
    output logic          o_ready,
    output logic          o_we,
    output logic [AW-1:0] o_waddr,
    output logic [15:0]   o_wdata,
    output logic          o_done
);

    localparam logic [AW-1:0] WPTR_MAX = AW'(MEM_WORDS - 1);

    ld_state_t     r_state;
    logic [AW-1:0] r_wptr;
    logic [7:0]    r_hi;
    logic          w_fire;

    assign o_ready = (r_state != RUN) && !rst;
    assign w_fire  = i_valid && o_ready;
    assign o_done  = (r_state == RUN);
    assign o_waddr = r_wptr;

    // A last byte arriving as a high byte still completes a word.
    always_comb begin
        o_we    = 1'b0;
        o_wdata = 16'h0000;
        if (w_fire) begin
            unique case (r_state)
                LOAD_HI: begin
                    if (i_last) begin
                        o_we    = 1'b1;
                        o_wdata = {i_data, 8'h00};
                    end
                end
                LOAD_LO: begin
                    o_we    = 1'b1;
                    o_wdata = {r_hi, i_data};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD_HI;
            r_wptr  <= '0;
            r_hi    <= 8'h00;
        end else if (w_fire) begin
            unique case (r_state)
                LOAD_HI: begin
                    if (i_last) begin
                        r_wptr  <= r_wptr + 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_hi    <= i_data;
                        r_state <= LOAD_LO;
                    end
                end
                LOAD_LO: begin
                    r_wptr <= r_wptr + 1'b1;
                    if (i_last || (r_wptr == WPTR_MAX)) begin
                        r_state <= RUN;
                    end else begin
                        r_state <= LOAD_HI;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/risc16_memsys.sv
// Unified RAM, MMIO block and boot loader for the RISC16 core:
// zero-wait instruction/data ports, GPIO, cycle counter, error flag.
module risc16_memsys
    import risc16_pkg::*;
#(
    parameter int          MEM_WORDS = MEM_WORDS_DEF,
    parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] iaddr,
    input  logic        ioe,
    output logic [15:0] idin,
    input  logic [15:0] daddr,
    input  logic [15:0] ddout,
    input  logic        doe,
    input  logic        dwe,
    output logic [15:0] ddin,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        cpu_rst,
    output logic [15:0] gpio_out,
    input  logic [15:0] gpio_in,
    output logic        bad_access
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [16:0] RAM_BYTES = 17'(2 * MEM_WORDS);

    logic [15:0]   r_mem [MEM_WORDS];
    logic          r_cpu_rst;
    logic [15:0]   r_gpio;
    logic [15:0]   r_cyc;
    logic          r_bad;

    logic          w_ld_we;
    logic [AW-1:0] w_ld_waddr;
    logic [15:0]   w_ld_wdata;
    logic          w_run;

    logic          w_i_ram;
    logic          w_i_bad;
    logic          w_d_ram;
    logic          w_d_gout;
    logic          w_d_gin;
    logic          w_d_cyc;
    logic          w_rd_ok;
    logic          w_wr_ok;
    logic          w_d_bad;
    logic          w_cpu_we;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [15:0]   w_wdata;
    logic [15:0]   w_ddin;

    risc16_loader #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_loader (
        .clk     (clk),
        .rst     (rst),
        .i_valid (ld_valid),
        .i_data  (ld_data),
        .i_last  (ld_last),
        .o_ready (ld_ready),
        .o_we    (w_ld_we),
        .o_waddr (w_ld_waddr),
        .o_wdata (w_ld_wdata),
        .o_done  (w_run)
    );

    assign w_i_ram = ({1'b0, iaddr} < RAM_BYTES);
    assign w_i_bad = ioe && !w_i_ram;
    assign idin    = (ioe && w_i_ram) ? r_mem[iaddr[AW:1]] : 16'h0000;

    // RAM wins any overlap with the MMIO window.
    assign w_d_ram  = ({1'b0, daddr} < RAM_BYTES);
    assign w_d_gout = !w_d_ram && (daddr == MMIO_BASE + MMIO_GPIO_OUT);
    assign w_d_gin  = !w_d_ram && (daddr == MMIO_BASE + MMIO_GPIO_IN);
    assign w_d_cyc  = !w_d_ram && (daddr == MMIO_BASE + MMIO_CYC_CNT);

    assign w_rd_ok = doe && !dwe &&
                     (w_d_ram || w_d_gout || w_d_gin || w_d_cyc);
    assign w_wr_ok = dwe && !doe && (w_d_ram || w_d_gout);
    assign w_d_bad = (doe || dwe) && !w_rd_ok && !w_wr_ok;

    always_comb begin
        w_ddin = 16'h0000;
        if (w_rd_ok) begin
            unique case (1'b1)
                w_d_ram:  w_ddin = r_mem[daddr[AW:1]];
                w_d_gout: w_ddin = r_gpio;
                w_d_gin:  w_ddin = gpio_in;
                w_d_cyc:  w_ddin = r_cyc;
                default:  w_ddin = 16'h0000;
            endcase
        end
    end

    assign ddin = w_ddin;

    // Loader and CPU never write in the same cycle: one only
    // runs before RUN, the other only in RUN.
    assign w_cpu_we = w_wr_ok && w_d_ram && w_run && !rst;
    assign w_we     = w_ld_we || w_cpu_we;
    assign w_waddr  = w_ld_we ? w_ld_waddr : daddr[AW:1];
    assign w_wdata  = w_ld_we ? w_ld_wdata : ddout;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_rst <= 1'b1;
            r_gpio    <= 16'h0000;
            r_cyc     <= 16'h0000;
            r_bad     <= 1'b0;
        end else begin
            r_cpu_rst <= !w_run;
            if (w_run) begin
                r_cyc <= r_cyc + 16'd1;
            end
            if (w_run && w_wr_ok && w_d_gout) begin
                r_gpio <= ddout;
            end
            if (w_d_bad || w_i_bad) begin
                r_bad <= 1'b1;
            end
        end
    end

    assign cpu_rst    = r_cpu_rst;
    assign gpio_out   = r_gpio;
    assign bad_access = r_bad;

endmodule
